// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants and types for the FIFO read-side stream controller.
package fifo_stream_reader_pkg;

  localparam int SKID_DEPTH      = 2;
  localparam int FIFO_RD_LATENCY = 1;

  typedef logic [1:0] credit_t;

  function automatic int beat_cnt_width(input int burst_len);
    return (burst_len > 1) ? $clog2(burst_len) : 1;
  endfunction

endpackage

// File: rtl/sync_skid_buffer.sv
// Two-entry ordered register buffer; head is always the oldest word.
module sync_skid_buffer
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_head_data,
  output credit_t               o_occupancy
);

  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;
  credit_t               r_occ;
  logic                  w_do_pop;

  assign w_do_pop = i_pop & (r_occ != 2'd0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else begin
      unique case ({i_push, w_do_pop})
        2'b10: begin
          if (r_occ == 2'd0) r_head <= i_push_data;
          else               r_tail <= i_push_data;
          if (r_occ != 2'd2) r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_head <= r_tail;
          r_occ  <= r_occ - 2'd1;
        end
        2'b11: begin
          // simultaneous push and pop: occupancy unchanged, order preserved
          if (r_occ == 2'd1) begin
            r_head <= i_push_data;
          end else begin
            r_head <= r_tail;
            r_tail <= i_push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_head_data = r_head;
  assign o_occupancy = r_occ;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a registered-read FIFO port into a valid/ready stream framed into
// fixed-length bursts; credit-based fetch keeps one word per cycle.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int BURST_LEN  = 8
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  output logic                                 fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]                fifo_rd_data,
  input  logic                                 fifo_empty,
  output logic [DATA_WIDTH-1:0]                m_data,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic                                 m_last,
  output logic [beat_cnt_width(BURST_LEN)-1:0] burst_count
);

  localparam int               CNT_W        = beat_cnt_width(BURST_LEN);
  localparam logic [CNT_W-1:0] LAST_BEAT    = CNT_W'(BURST_LEN - 1);
  localparam credit_t          CREDIT_LIMIT = credit_t'(SKID_DEPTH);

  // one bit per cycle of FIFO read latency; the oldest bit strobes capture
  logic [FIFO_RD_LATENCY-1:0] r_in_flight;
  logic [CNT_W-1:0]           r_burst_count;
  credit_t                    w_occ;
  credit_t                    w_credits;
  credit_t                    w_credits_after_pop;
  logic                       w_capture;
  logic                       w_pop;

  assign w_capture = r_in_flight[FIFO_RD_LATENCY-1];
  assign w_pop     = m_valid & m_ready;

  // Stage: fetch request (combinational on m_ready for full throughput)
  assign w_credits           = w_occ + credit_t'($countones(r_in_flight));
  assign w_credits_after_pop = w_credits - credit_t'(w_pop);
  assign fifo_rd_en          = reset_n & ~fifo_empty & (w_credits_after_pop < CREDIT_LIMIT);

  always_ff @(posedge clk) begin
    if (!reset_n) r_in_flight <= '0;
    else          r_in_flight <= FIFO_RD_LATENCY'({r_in_flight, fifo_rd_en});
  end

  // Stage: capture returning word into the skid buffer
  sync_skid_buffer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_push      (w_capture),
    .i_push_data (fifo_rd_data),
    .i_pop       (w_pop),
    .o_head_data (m_data),
    .o_occupancy (w_occ)
  );

  // Stage: stream output and burst framing
  assign m_valid = (w_occ != 2'd0);
  assign m_last  = m_valid & (r_burst_count == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_burst_count <= '0;
    end else if (w_pop) begin
      r_burst_count <= (r_burst_count == LAST_BEAT) ? '0 : r_burst_count + CNT_W'(1);
    end
  end

  assign burst_count = r_burst_count;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed and randomized checks of fifo_stream_reader against a simple FIFO model.
module tb_fifo_stream_reader;

  localparam int DW = 16;
  localparam int BL = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_empty;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          m_last;
  logic [2:0]    burst_count;

  int n_assert = 0;
  int n_fail   = 0;

  fifo_stream_reader #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_last       (m_last),
    .burst_count  (burst_count)
  );

  always #5 clk = ~clk;

  // FIFO model: registered read, junk data on cycles without a read
  logic [DW-1:0] mem [0:4095];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  logic          gap = 1'b0;

  assign fifo_empty = (rd_ptr == wr_ptr) || gap;

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_rd_data <= mem[rd_ptr];
      rd_ptr       <= rd_ptr + 1;
    end else begin
      fifo_rd_data <= 16'hDEAD;
    end
  end

  // Monitor: logs handshakes and counts protocol violations
  int            n_fetch = 0;
  int            n_hs = 0;
  int            viol_empty = 0;
  int            viol_credit = 0;
  int            viol_stable = 0;
  logic          prev_valid = 1'b0;
  logic          prev_ready = 1'b0;
  logic          prev_rst = 1'b0;
  logic          last_rd_en = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [DW-1:0] log_data [0:2047];
  logic          log_last [0:2047];
  logic [2:0]    log_cnt  [0:2047];

  always @(negedge clk) begin
    prev_valid <= m_valid;
    prev_ready <= m_ready;
    prev_data  <= m_data;
    prev_rst   <= reset_n;
    last_rd_en <= fifo_rd_en;
    if (fifo_rd_en && fifo_empty) viol_empty <= viol_empty + 1;
    if (reset_n && prev_rst && prev_valid && !prev_ready && (!m_valid || m_data !== prev_data))
      viol_stable <= viol_stable + 1;
    if (!reset_n) begin
      n_fetch <= 0;
      n_hs    <= 0;
    end else begin
      if (n_fetch - n_hs > 2) viol_credit <= viol_credit + 1;
      if (fifo_rd_en) n_fetch <= n_fetch + 1;
      if (m_valid && m_ready) begin
        log_data[n_hs] <= m_data;
        log_last[n_hs] <= m_last;
        log_cnt[n_hs]  <= burst_count;
        n_hs           <= n_hs + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] v);
    mem[wr_ptr] = v;
    wr_ptr++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    push(16'hA5A5);
    m_ready = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_assert++;
      if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en cycle %0d: got %b want 0", i, fifo_rd_en); end
      tick();
    end
    reset_n = 1'b1;
    n_assert++;
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    n_assert++;
    if (m_last !== 1'b0) begin n_fail++; $display("FAIL reset_m_last: got %b want 0", m_last); end
    n_assert++;
    if (burst_count !== 3'd0) begin n_fail++; $display("FAIL reset_burst_count: got %0d want 0", burst_count); end
    n_assert++;
    if (m_data !== 16'h0000) begin n_fail++; $display("FAIL reset_m_data: got %h want 0000", m_data); end
    #1;
  endtask

  task automatic test_single();
    n_assert++;
    if (fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL single_rd_en_N: got %b want 1", fifo_rd_en); end
    tick();
    n_assert++;
    if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL single_rd_en_N1: got %b want 0", fifo_rd_en); end
    n_assert++;
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_N1: got %b want 0", m_valid); end
    tick();
    n_assert++;
    if (m_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid_N2: got %b want 1", m_valid); end
    n_assert++;
    if (m_data !== 16'hA5A5) begin n_fail++; $display("FAIL single_data: got %h want a5a5", m_data); end
    n_assert++;
    if (m_last !== 1'b0) begin n_fail++; $display("FAIL single_last: got %b want 0", m_last); end
    tick();
    n_assert++;
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_after: got %b want 0", m_valid); end
    n_assert++;
    if (burst_count !== 3'd1) begin n_fail++; $display("FAIL single_burst_count: got %0d want 1", burst_count); end
  endtask

  task automatic test_stream();
    m_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 16; k++) push(16'(k));
    n_assert++;
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL stream_fill0: got %b want 0", m_valid); end
    tick();
    n_assert++;
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL stream_fill1: got %b want 0", m_valid); end
    tick();
    for (int i = 0; i < 16; i++) begin
      n_assert++;
      if (m_valid !== 1'b1 || m_data !== 16'(i))
        begin n_fail++; $display("FAIL stream_beat %0d: got valid=%b data=%h want valid=1 data=%h", i, m_valid, m_data, 16'(i)); end
      n_assert++;
      if (m_last !== (i % 8 == 7) || burst_count !== 3'(i % 8))
        begin n_fail++; $display("FAIL stream_frame %0d: got last=%b cnt=%0d want last=%b cnt=%0d", i, m_last, burst_count, (i % 8 == 7), i % 8); end
      tick();
    end
    n_assert++;
    if (m_valid !== 1'b0 || burst_count !== 3'd0)
      begin n_fail++; $display("FAIL stream_end: got valid=%b cnt=%0d want 0 0", m_valid, burst_count); end
  endtask

  task automatic test_backpressure();
    int cyc;
    m_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 10; k++) push(16'(k));
    for (int i = 0; i < 20; i++) begin
      tick();
      if (m_valid) begin
        n_assert++;
        if (m_data !== 16'h0000) begin n_fail++; $display("FAIL bp_hold_data cycle %0d: got %h want 0000", i, m_data); end
      end
    end
    n_assert++;
    if (n_fetch !== 2) begin n_fail++; $display("FAIL bp_fetch_count: got %0d want 2", n_fetch); end
    n_assert++;
    if (m_valid !== 1'b1 || m_data !== 16'h0000)
      begin n_fail++; $display("FAIL bp_head: got valid=%b data=%h want 1 0000", m_valid, m_data); end
    m_ready = 1'b1;
    cyc = 0;
    while (n_hs < 10 && cyc < 60) begin tick(); cyc++; end
    tick();
    n_assert++;
    if (n_hs !== 10) begin n_fail++; $display("FAIL bp_drain_count: got %0d want 10", n_hs); end
    for (int k = 0; k < 10; k++) begin
      n_assert++;
      if (log_data[k] !== 16'(k) || log_last[k] !== (k == 7) || log_cnt[k] !== 3'(k % 8))
        begin n_fail++; $display("FAIL bp_order %0d: got data=%h last=%b cnt=%0d want data=%h last=%b cnt=%0d", k, log_data[k], log_last[k], log_cnt[k], 16'(k), (k == 7), k % 8); end
    end
    n_assert++;
    if (n_fetch !== 10 || m_valid !== 1'b0)
      begin n_fail++; $display("FAIL bp_final: got fetch=%0d valid=%b want 10 0", n_fetch, m_valid); end
    m_ready = 1'b0;
  endtask

  task automatic test_random();
    int base;
    int pushed;
    int cyc;
    int errs;
    do_reset();
    base   = wr_ptr;
    pushed = 0;
    cyc    = 0;
    while (n_hs < 1000 && cyc < 20000) begin
      if (pushed < 1000 && $urandom_range(0, 2) != 0) begin push(16'($urandom)); pushed++; end
      gap     = ($urandom_range(0, 3) == 0);
      m_ready = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    gap     = 1'b0;
    m_ready = 1'b0;
    tick();
    n_assert++;
    if (n_hs !== 1000) begin n_fail++; $display("FAIL rand_count: got %0d want 1000", n_hs); end
    errs = 0;
    for (int k = 0; k < 1000; k++) begin
      n_assert++;
      if (log_data[k] !== mem[base + k] || log_last[k] !== (k % 8 == 7) || log_cnt[k] !== 3'(k % 8)) begin
        n_fail++;
        errs++;
        if (errs <= 5)
          $display("FAIL rand_beat %0d: got data=%h last=%b cnt=%0d want data=%h last=%b cnt=%0d", k, log_data[k], log_last[k], log_cnt[k], mem[base + k], (k % 8 == 7), k % 8);
      end
    end
    n_assert++;
    if (viol_empty !== 0) begin n_fail++; $display("FAIL rd_en_while_empty: got %0d events want 0", viol_empty); end
    n_assert++;
    if (viol_credit !== 0) begin n_fail++; $display("FAIL credit_limit: got %0d events want 0", viol_credit); end
    n_assert++;
    if (viol_stable !== 0) begin n_fail++; $display("FAIL stall_stability: got %0d events want 0", viol_stable); end
  endtask

  task automatic test_mid_reset();
    int cyc;
    m_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 16; k++) push(16'h0100 + 16'(k));
    cyc = 0;
    while (n_hs < 3 && cyc < 20) begin tick(); cyc++; end
    n_assert++;
    if (n_hs !== 3) begin n_fail++; $display("FAIL mid_pre_hs: got %0d want 3", n_hs); end
    n_assert++;
    if (last_rd_en !== 1'b1) begin n_fail++; $display("FAIL mid_pre_rd_en: got %b want 1", last_rd_en); end
    reset_n = 1'b0;
    #1;
    n_assert++;
    if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL mid_rd_en_in_reset: got %b want 0", fifo_rd_en); end
    tick();
    reset_n = 1'b1;
    #1;
    n_assert++;
    if (m_valid !== 1'b0 || burst_count !== 3'd0)
      begin n_fail++; $display("FAIL mid_after_reset: got valid=%b cnt=%0d want 0 0", m_valid, burst_count); end
    tick();
    n_assert++;
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL mid_inflight_dropped: got valid=%b data=%h want valid=0", m_valid, m_data); end
    cyc = 0;
    while (n_hs < 11 && cyc < 40) begin tick(); cyc++; end
    tick();
    n_assert++;
    if (n_hs !== 11) begin n_fail++; $display("FAIL mid_resume_count: got %0d want 11", n_hs); end
    for (int k = 0; k < 11; k++) begin
      n_assert++;
      if (log_data[k] !== 16'h0105 + 16'(k) || log_last[k] !== (k == 7))
        begin n_fail++; $display("FAIL mid_resume %0d: got data=%h last=%b want data=%h last=%b", k, log_data[k], log_last[k], 16'h0105 + 16'(k), (k == 7)); end
    end
    m_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
Single-clock read-side controller for the team's dual-clock gray-pointer FIFO. It drains the FIFO's registered read port (rd_en/rd_data/empty, 1-cycle read latency) and presents the words as a valid/ready stream. A 2-entry skid buffer absorbs the read latency, so the block sustains one word per cycle under continuous m_ready. A beat counter frames the stream into fixed-length bursts with m_last.

Parameters:
DATA_WIDTH, 16, width of FIFO words and stream data
BURST_LEN, 8, beats per burst (≥1); m_last marks the final beat of each burst

Ports:
clk  input  1  sole clock; FIFO read side and stream share it
reset_n  input  1  synchronous, active-low reset
fifo_rd_en  output  1  read request to the FIFO read port
fifo_rd_data  input  DATA_WIDTH  FIFO read data, valid the cycle after an accepted rd_en
fifo_empty  input  1  FIFO empty flag, same clock domain
m_data  output  DATA_WIDTH  stream data
m_valid  output  1  stream data valid
m_ready  input  1  downstream accept
m_last  output  1  last beat of current burst
burst_count  output  max(1,$clog2(BURST_LEN))  beat index within current burst

Behaviour:
- Reset is synchronous, active-low. It is sampled on the clk edge.
- Reset values: fifo_rd_en=0 (also forced 0 combinationally while reset_n=0), m_valid=0, m_last=0, burst_count=0, m_data=0, buffer occupancy=0, in-flight flag=0.
- Credit count = buffer occupancy (0..2) + in_flight (0/1).
  - in_flight is a register: it is set in the cycle after fifo_rd_en=1 and cleared when the data is captured.
- Read request: fifo_rd_en = reset_n & ~fifo_empty & ((credits − pop) < 2), where pop = m_valid & m_ready.
  - This is combinational from m_ready and fifo_empty, which is intentional because it gives full throughput.
- Never assert fifo_rd_en while fifo_empty=1. Each fifo_rd_en pulse therefore consumes exactly one word.
- Capture: when in_flight=1, fifo_rd_data is written into the buffer tail at the end of that cycle.
- Latency: rd_en in cycle N → data on fifo_rd_data in N+1 → m_valid=1 with that word in N+2.
- Buffer is an ordered 2-entry FIFO. m_data is driven from the head register. Capture and pop in the same cycle are legal; occupancy stays the same.
- Credits never exceed 2, so no capture is ever dropped.
- Stream rules:
  - Once m_valid=1, m_valid and m_data hold until m_ready=1.
  - m_valid = (occupancy≠0).
  - There is no combinational path from fifo_rd_data to m_data.
- Steady state with m_ready=1 and the FIFO non-empty: occupancy=1, in_flight=1, one beat per cycle.
- Burst framing:
  - m_last = m_valid & (burst_count == BURST_LEN−1).
  - burst_count increments on each handshake and wraps to 0 after BURST_LEN−1.
  - For BURST_LEN=1, m_last = m_valid and burst_count stays 0.
- Boundary conditions:
  - FIFO goes empty mid-burst: m_valid deasserts once the buffer drains. burst_count holds, and the burst resumes later with no m_last inserted.
  - m_ready low: at most 2 words are fetched (credit-limited), then fifo_rd_en stays 0.
  - Reset during an in-flight read: the returning word is discarded, because in_flight is cleared by reset. The buffer empties and burst_count=0. That word is lost by design (no flush).

Decomposition:
- Package fifo_stream_reader_pkg holds:
  - localparam SKID_DEPTH=2
  - localparam FIFO_RD_LATENCY=1
  - typedef credit_t (2-bit)
  - function beat_cnt_width(BURST_LEN)
- One sub-module, sync_skid_buffer: a 2-entry ordered register buffer with push/pop/occupancy, parameterised on DATA_WIDTH, clk/reset_n.
- The top level holds the credit logic and the burst counter.

Test Plan:
1. Reset: reset_n=0 for 3 cycles with fifo_empty=0 → fifo_rd_en=0 throughout; m_valid=0, m_last=0, burst_count=0 on the first cycle after release.
2. Single word: FIFO holds 0xA5A5, m_ready=1, BURST_LEN=8 → one rd_en pulse in cycle N; m_valid=1 with m_data=0xA5A5 in N+2; m_last=0; burst_count becomes 1.
3. Streaming: 16 words 0x0000..0x000F, m_ready held 1 → after 2-cycle fill, one handshake per cycle for 16 consecutive cycles; m_last=1 on words 0x0007 and 0x000F only.
4. Backpressure: 10 words queued, m_ready=0 for 20 cycles → exactly 2 rd_en pulses; m_valid=1 with m_data=0x0000 held stable. Releasing m_ready → words 0..9 in order, no loss or duplication.
5. Random stress: 1000 words, random m_ready (50%) and random fifo_empty gaps → scoreboard exact match. Assertions: no rd_en while empty, credits ≤2, m_data stable while m_valid & ~m_ready.
6. Mid-burst reset: reset after 3 handshakes with rd_en asserted the cycle before → next cycle m_valid=0, burst_count=0. The in-flight word is never presented. Subsequent words restart framing, with m_last on the 8th beat.
